// File: rtl/innovated_alarm_clock_pkg.sv
// Shared types, lookup tables and small arithmetic helpers for the alarm clock.
package innovated_alarm_clock_pkg;

  localparam logic [2:0] DIG_S0 = 3'd0;
  localparam logic [2:0] DIG_S1 = 3'd1;
  localparam logic [2:0] DIG_M0 = 3'd2;
  localparam logic [2:0] DIG_M1 = 3'd3;
  localparam logic [2:0] DIG_H0 = 3'd4;
  localparam logic [2:0] DIG_H1 = 3'd5;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam logic [7:0] SEG_OFF     = 8'hFF;
  localparam logic [7:0] AN_OFF      = 8'hFF;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
  } wall_time_t;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] minute;
  } alarm_time_t;

  function automatic logic [4:0] inc_hour(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_sixty(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // 0 reads as 12 and the afternoon hours fold back onto 1..11.
  function automatic logic [4:0] hour_12(input logic [4:0] h);
    if (h == 5'd0)      return 5'd12;
    else if (h > 5'd12) return h - 5'd12;
    else                return h;
  endfunction

  function automatic logic [3:0] tens_digit(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] ones_digit(input logic [5:0] v);
    logic [5:0] t;
    t = v % 6'd10;
    return t[3:0];
  endfunction

  // Active-low {dp,g,f,e,d,c,b,a}; anything outside 0-9 is blank.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return SEG_OFF;
    endcase
  endfunction

  function automatic logic [9:0] note_freq(input logic [2:0] idx);
    case (idx)
      3'd0:    return 10'd262;
      3'd1:    return 10'd294;
      3'd2:    return 10'd330;
      3'd3:    return 10'd349;
      3'd4:    return 10'd392;
      3'd5:    return 10'd440;
      3'd6:    return 10'd494;
      default: return 10'd523;
    endcase
  endfunction

  // Every branch divides a parameter by a literal, so this folds to a constant table.
  function automatic int note_half_period(input int clk_hz, input logic [2:0] idx);
    int p;
    case (idx)
      3'd0:    p = clk_hz / 524;
      3'd1:    p = clk_hz / 588;
      3'd2:    p = clk_hz / 660;
      3'd3:    p = clk_hz / 698;
      3'd4:    p = clk_hz / 784;
      3'd5:    p = clk_hz / 880;
      3'd6:    p = clk_hz / 988;
      default: p = clk_hz / 1046;
    endcase
    return (p < 1) ? 1 : p;
  endfunction

  function automatic logic [2:0] note_color(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd3, 3'd6: return 3'b100;
      3'd1, 3'd4, 3'd7: return 3'b010;
      default:          return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stability counter; emits one pulse per accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 25_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], raw};
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    // Any cycle that agrees with the accepted level restarts the stability count.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
        pulse_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = pulse_q;

endmodule

// File: rtl/innovated_alarm_clock.sv
// 24-hour alarm clock: timekeeping, button editing, melody/LED alarm and a
// multiplexed 12-hour seven-segment display.
module innovated_alarm_clock
  import innovated_alarm_clock_pkg::*;
#(
  parameter int CLK_HZ          = 5_000_000,
  parameter int DEBOUNCE_CYCLES = 25_000,
  parameter int SCAN_CYCLES     = 5_000,
  parameter int NOTE_CYCLES     = 1_250_000
) (
  input  logic       fiveMhz,
  input  logic       reset,
  input  logic       alarmEnable,
  input  logic       timeChange,
  input  logic       alarmChange,
  input  logic       minutes,
  input  logic       hours,
  output logic       alarmEnabled,
  output logic       alarmOn,
  output logic       amPMLED,
  output logic [7:0] seg,
  output logic [7:0] an,
  output logic       pwmSound,
  output logic       pwmControl,
  output logic [2:0] rgb1,
  output logic [2:0] rgb2,
  output logic [9:0] currentNote
);

  localparam int SUB_W   = $clog2(CLK_HZ + 1);
  localparam int QUARTER = CLK_HZ / 4;
  localparam int BLINK_W = $clog2(QUARTER + 1);
  localparam int NOTE_W  = $clog2(NOTE_CYCLES + 1);
  localparam int TONE_W  = $clog2(CLK_HZ / 524 + 2);
  localparam int SCAN_W  = $clog2(SCAN_CYCLES + 1);
  localparam int BEAT_ON = NOTE_CYCLES * 3 / 4;

  logic hour_pulse, min_pulse;
  logic unused_hours_level, unused_minutes_level;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hours_db (
    .clk        (fiveMhz),
    .reset      (reset),
    .raw        (hours),
    .level      (unused_hours_level),
    .rise_pulse (hour_pulse)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_minutes_db (
    .clk        (fiveMhz),
    .reset      (reset),
    .raw        (minutes),
    .level      (unused_minutes_level),
    .rise_pulse (min_pulse)
  );

  logic [SUB_W-1:0]   sub_q, sub_d;
  wall_time_t         now_q, now_d;
  alarm_time_t        alarm_q, alarm_d;
  logic               ring_q, ring_d;
  logic [2:0]         note_idx_q, note_idx_d;
  logic [NOTE_W-1:0]  note_cnt_q, note_cnt_d;
  logic [TONE_W-1:0]  tone_cnt_q, tone_cnt_d;
  logic               pwm_q, pwm_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         digit_idx_q, digit_idx_d;
  logic [7:0]         an_q, an_d;
  logic [7:0]         seg_q, seg_d;
  logic               alarm_enabled_q;

  logic       ringing;
  logic       alarm_view;
  logic [4:0] disp_hour, disp_hour_12;
  logic [5:0] disp_min, disp_sec;
  logic [3:0] digit_val;

  // NOTE: every *_d gets its default before any branch, so no path leaves a latch.
  always_comb begin
    sub_d = sub_q + 1'b1;
    now_d = now_q;
    if (sub_q == SUB_W'(CLK_HZ - 1)) begin
      sub_d        = '0;
      now_d.second = inc_sixty(now_q.second);
      if (now_q.second == 6'd59) begin
        now_d.minute = inc_sixty(now_q.minute);
        if (now_q.minute == 6'd59) now_d.hour = inc_hour(now_q.hour);
      end
    end

    // Edits are applied after the carry chain so they win on the edited field.
    alarm_d = alarm_q;
    if (timeChange) begin
      if (hour_pulse) now_d.hour = inc_hour(now_q.hour);
      if (min_pulse) begin
        now_d.minute = inc_sixty(now_q.minute);
        now_d.second = '0;
        sub_d        = '0;
      end
    end else if (alarmChange) begin
      if (hour_pulse) alarm_d.hour   = inc_hour(alarm_q.hour);
      if (min_pulse)  alarm_d.minute = inc_sixty(alarm_q.minute);
    end
  end

  assign ringing = alarmEnable && !timeChange && !alarmChange &&
                   (now_q.hour == alarm_q.hour) && (now_q.minute == alarm_q.minute);

  // Melody state restarts from zero on the first ringing cycle and is held clear otherwise.
  always_comb begin
    ring_d      = ringing;
    note_idx_d  = '0;
    note_cnt_d  = '0;
    tone_cnt_d  = '0;
    pwm_d       = 1'b0;
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (ringing && ring_q) begin
      note_idx_d  = note_idx_q;
      note_cnt_d  = note_cnt_q + 1'b1;
      tone_cnt_d  = tone_cnt_q + 1'b1;
      pwm_d       = pwm_q;
      blink_cnt_d = blink_cnt_q + 1'b1;
      blink_d     = blink_q;
      if (note_cnt_q == NOTE_W'(NOTE_CYCLES - 1)) begin
        note_cnt_d = '0;
        note_idx_d = note_idx_q + 3'd1;
        tone_cnt_d = '0;
        pwm_d      = 1'b0;
      end else if (tone_cnt_q == TONE_W'(note_half_period(CLK_HZ, note_idx_q) - 1)) begin
        tone_cnt_d = '0;
        pwm_d      = ~pwm_q;
      end
      if (blink_cnt_q == BLINK_W'(QUARTER - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end
    end
  end

  assign alarm_view   = alarmChange && !timeChange;
  assign disp_hour    = alarm_view ? alarm_q.hour   : now_q.hour;
  assign disp_min     = alarm_view ? alarm_q.minute : now_q.minute;
  assign disp_sec     = alarm_view ? 6'd0           : now_q.second;
  assign disp_hour_12 = hour_12(disp_hour);

  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1)) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 3'd1;
    end

    case (digit_idx_q)
      DIG_H1:  digit_val = tens_digit({1'b0, disp_hour_12});
      DIG_H0:  digit_val = ones_digit({1'b0, disp_hour_12});
      DIG_M1:  digit_val = tens_digit(disp_min);
      DIG_M0:  digit_val = ones_digit(disp_min);
      DIG_S1:  digit_val = tens_digit(disp_sec);
      DIG_S0:  digit_val = ones_digit(disp_sec);
      default: digit_val = BLANK_DIGIT;
    endcase
    an_d  = ~(8'b1 << digit_idx_q);
    seg_d = seg_decode(digit_val);
  end

  // NOTE: state is updated with <= so every flop samples the same pre-edge values.
  always_ff @(posedge fiveMhz) begin
    if (reset) begin
      sub_q       <= '0;
      now_q       <= '0;
      alarm_q     <= '0;
      ring_q      <= 1'b0;
      note_idx_q  <= '0;
      note_cnt_q  <= '0;
      tone_cnt_q  <= '0;
      pwm_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
    end else begin
      sub_q       <= sub_d;
      now_q       <= now_d;
      alarm_q     <= alarm_d;
      ring_q      <= ring_d;
      note_idx_q  <= note_idx_d;
      note_cnt_q  <= note_cnt_d;
      tone_cnt_q  <= tone_cnt_d;
      pwm_q       <= pwm_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  // Deliberately outside the reset branch: it tracks the switch even while reset is held.
  always_ff @(posedge fiveMhz) begin
    alarm_enabled_q <= alarmEnable;
  end

  assign alarmEnabled = alarm_enabled_q;
  assign alarmOn      = ring_q && !blink_q;
  assign pwmSound     = ring_q && pwm_q;
  assign pwmControl   = ring_q && (note_cnt_q < NOTE_W'(BEAT_ON));
  assign rgb1         = ring_q ? note_color(note_idx_q) : 3'b000;
  assign rgb2         = ring_q ? ~note_color(note_idx_q) : 3'b000;
  assign currentNote  = ring_q ? note_freq(note_idx_q) : 10'd0;
  assign amPMLED      = (disp_hour >= 5'd12);
  assign an           = an_q;
  assign seg          = seg_q;

endmodule

// File: tb/tb_innovated_alarm_clock.sv
// Directed bench for innovated_alarm_clock with shrunken timing parameters.
module tb_innovated_alarm_clock;

  localparam int CLK_HZ = 1100;
  localparam int DEB    = 4;
  localparam int SCAN   = 3;
  localparam int NOTE   = 40;

  logic       fiveMhz = 1'b0;
  logic       reset, alarmEnable, timeChange, alarmChange, minutes, hours;
  logic       alarmEnabled, alarmOn, amPMLED, pwmSound, pwmControl;
  logic [7:0] seg, an;
  logic [2:0] rgb1, rgb2;
  logic [9:0] currentNote;

  int n_checks = 0;
  int n_errors = 0;

  innovated_alarm_clock #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .SCAN_CYCLES(SCAN), .NOTE_CYCLES(NOTE)
  ) dut (
    .fiveMhz(fiveMhz), .reset(reset), .alarmEnable(alarmEnable),
    .timeChange(timeChange), .alarmChange(alarmChange),
    .minutes(minutes), .hours(hours),
    .alarmEnabled(alarmEnabled), .alarmOn(alarmOn), .amPMLED(amPMLED),
    .seg(seg), .an(an), .pwmSound(pwmSound), .pwmControl(pwmControl),
    .rgb1(rgb1), .rgb2(rgb2), .currentNote(currentNote)
  );

  always #5 fiveMhz = ~fiveMhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge fiveMhz);
  endtask

  task automatic press(input bit is_hour, input int n);
    for (int i = 0; i < n; i++) begin
      if (is_hour) hours = 1'b1; else minutes = 1'b1;
      step(2 * DEB);
      hours   = 1'b0;
      minutes = 1'b0;
      step(2 * DEB);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
      4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
      4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
      4'd9: return 8'h90;  default: return 8'hFF;
    endcase
  endfunction

  // Waits (bounded) for anode k to be selected, then compares its segments.
  task automatic check_digit(input string tag, input int k, input logic [3:0] d);
    logic [7:0] pat;
    logic [7:0] s;
    logic       ok;
    pat = ~(8'h01 << k);
    s   = 8'hxx;
    ok  = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (an === pat) begin
        s  = seg;
        ok = 1'b1;
      end else begin
        @(negedge fiveMhz);
      end
    end
    check($sformatf("%s_d%0d", tag, k), {23'd0, ok, s}, {23'd0, 1'b1, seg_of(d)});
  endtask

  // bcd nibbles are H1 H0 M1 M0 S1 S0, most significant first.
  task automatic check_display(input string tag, input logic [23:0] bcd);
    for (int k = 0; k < 6; k++) check_digit(tag, k, bcd[4*k +: 4]);
  endtask

  initial begin
    reset = 1'b1; alarmEnable = 1'b1; timeChange = 1'b0; alarmChange = 1'b0;
    minutes = 1'b0; hours = 1'b0;
    step(3);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 8'hFF);
    check("rst_alarmOn", alarmOn, 0);
    check("rst_note", currentNote, 0);
    check("rst_rgb", {rgb1, rgb2}, 0);
    check("rst_pwm", {pwmSound, pwmControl}, 0);
    check("rst_enabled", alarmEnabled, 1);

    // Ringing from the first edge after release.
    reset = 1'b0;
    step(1);
    check("ring_alarmOn", alarmOn, 1);
    check("ring_note0", currentNote, 262);
    check("ring_beat", pwmControl, 1);
    check("ring_rgb1", rgb1, 3'b100);
    check("ring_rgb2", rgb2, 3'b011);
    check("ring_pwm_e1", pwmSound, 0);
    step(1);
    check("ring_pwm_e2", pwmSound, 0);
    step(1);
    check("ring_pwm_e3", pwmSound, 1);
    step(27);
    check("beat_e30", pwmControl, 1);
    step(1);
    check("beat_e31", pwmControl, 0);
    step(9);
    check("note_e40", currentNote, 262);
    step(1);
    check("note_e41", currentNote, 294);
    check("rgb_e41", rgb1, 3'b010);
    step(234);
    check("blink_e275", alarmOn, 1);
    step(1);
    check("blink_e276", alarmOn, 0);
    check_display("disp_reset", 24'h120000);
    check("ampm_reset", amPMLED, 0);

    // Edit time to 02:02; ringing must stop as soon as timeChange is held.
    timeChange = 1'b1;
    step(1);
    check("edit_alarmOn", alarmOn, 0);
    check("edit_pwm", pwmSound, 0);
    check("edit_note", currentNote, 0);
    press(1'b1, 2);
    press(1'b0, 2);
    check_display("time_0202", 24'h020200);

    // Edit alarm to 02:02 and release: alarm matches time again.
    timeChange  = 1'b0;
    alarmChange = 1'b1;
    press(1'b1, 2);
    press(1'b0, 2);
    check_display("alarm_view", 24'h020200);
    check("ampm_alarm", amPMLED, 0);
    alarmChange = 1'b0;
    step(1);
    check("resume_alarmOn", alarmOn, 1);
    check("resume_note", currentNote, 262);

    alarmEnable = 1'b0;
    step(1);
    check("disarm_alarmOn", alarmOn, 0);
    check("disarm_beat", pwmControl, 0);
    check("disarm_rgb", {rgb1, rgb2}, 0);
    check("disarm_note", currentNote, 0);
    check("disarm_enabled", alarmEnabled, 0);

    // 13:xx shows 01 PM; then 23:59 and roll through midnight.
    timeChange = 1'b1;
    press(1'b1, 11);
    check_digit("h13", 5, 4'd0);
    check_digit("h13", 4, 4'd1);
    check("ampm_13", amPMLED, 1);
    press(1'b1, 10);
    press(1'b0, 57);
    check_display("t2359", 24'h115900);
    check("ampm_23", amPMLED, 1);
    timeChange = 1'b0;
    step(59 * CLK_HZ);
    check_display("t235959", 24'h115959);
    step(CLK_HZ);
    check_display("midnight", 24'h120000);
    check("ampm_midnight", amPMLED, 0);

    // A hours glitch shorter than the debounce window must be ignored.
    timeChange = 1'b1;
    hours = 1'b1;
    step(DEB - 1);
    hours = 1'b0;
    step(2 * DEB);
    check_digit("glitch", 5, 4'd1);
    check_digit("glitch", 4, 4'd2);
    press(1'b1, 2);
    press(1'b0, 2);
    check_display("time2_0202", 24'h020200);

    // Ring again, then reset in the middle of it.
    timeChange  = 1'b0;
    alarmEnable = 1'b1;
    step(1);
    check("ring2_alarmOn", alarmOn, 1);
    step(5);
    reset = 1'b1;
    step(1);
    check("midrst_an", an, 8'hFF);
    check("midrst_seg", seg, 8'hFF);
    check("midrst_alarmOn", alarmOn, 0);
    check("midrst_note", currentNote, 0);
    check("midrst_pwm", {pwmSound, pwmControl}, 0);
    check("midrst_rgb", {rgb1, rgb2}, 0);
    reset = 1'b0;
    step(1);
    check("postrst_note", currentNote, 262);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
